// File: rtl/sr_sched_pkg.sv
// Shared definitions for the SR bank scheduler: op codes, sequencer states
// and the round-robin pick helper.
package sr_sched_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned IDW      = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_APPLY = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  // First set bit strictly after ptr, wrapping modulo nreq; the nearest
  // candidate is visited last so it overwrites any farther one.
  function automatic logic [IDW-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                             input logic [IDW-1:0]      ptr,
                                             input int unsigned         nreq);
    logic [IDW-1:0] win;
    int             cand;
    win = ptr;
    for (int i = int'(MAX_NREQ); i >= 1; i--) begin
      if (i <= int'(nreq)) begin
        cand = (int'(ptr) + i) % int'(nreq);
        if (req[IDW'(cand)]) win = IDW'(cand);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sr_bank_scheduler_if.sv
// Request/grant/completion bundle between the control agents and the
// SR bank scheduler.
interface sr_bank_scheduler_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 3
);

  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    op;
  logic [IDXW*NREQ-1:0] idx;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic                 err;
  logic                 busy;
  logic [WIDTH-1:0]     q;

  modport master (output req, op, idx, input gnt, done, err, busy, q);
  modport slave  (input req, op, idx, output gnt, done, err, busy, q);

endinterface

// File: rtl/sr_cell.sv
// One synchronous SR storage cell; the illegal s=r=1 pair is treated as hold.
module sr_cell (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst)            q <= 1'b0;
    else if (s && !r)    q <= 1'b1;
    else if (r && !s)    q <= 1'b0;
  end

endmodule

// File: rtl/sr_bank_scheduler.sv
// Round-robin scheduler sharing a bank of WIDTH SR cells among NREQ requesters.
// Build option SR_TOGGLE_EN: when defined op 11 toggles the cell, otherwise it is rejected with err.
module sr_bank_scheduler
  import sr_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  sr_bank_scheduler_if.slave bus
);

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   pick;
  logic [1:0]       cmd_op;
  logic [1:0]       pick_op;
  logic [IDXW-1:0]  cmd_idx;
  logic [IDXW-1:0]  pick_idx;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  done;
  logic             err;
  logic             busy;
  logic [WIDTH-1:0] s_vec;
  logic [WIDTH-1:0] r_vec;
  logic [WIDTH-1:0] q_vec;
  logic             idx_ok;
  logic             op_ok;
  logic             q_sel;
  logic             exp_bit;
  logic             s_bit;
  logic             r_bit;
  logic             cell_nxt;
  logic             chk_err;

  assign pick = rr_pick(MAX_NREQ'(bus.req), ptr, NREQ);

  // Command fields of the requester the arbiter would pick this cycle
  always_comb begin
    pick_op  = OP_HOLD;
    pick_idx = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick == IDW'(i)) begin
        pick_op  = bus.op[2*i +: 2];
        pick_idx = bus.idx[IDXW*i +: IDXW];
      end
    end
  end

  // Cell drive and self-check; s/r are only non-zero in APPLY for a legal command
  always_comb begin
    idx_ok = 32'(cmd_idx) < WIDTH;
`ifdef SR_TOGGLE_EN
    op_ok  = 1'b1;
`else
    op_ok  = (cmd_op != OP_TOGGLE);
`endif
    q_sel = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (cmd_idx == IDXW'(i)) q_sel = q_vec[i];
    end

    exp_bit = q_sel;
    case (cmd_op)
      OP_SET:    exp_bit = 1'b1;
      OP_RESET:  exp_bit = 1'b0;
`ifdef SR_TOGGLE_EN
      OP_TOGGLE: exp_bit = ~q_sel;
`endif
      default:   exp_bit = q_sel;
    endcase

    s_bit = 1'b0;
    r_bit = 1'b0;
    if (state == S_APPLY && idx_ok && op_ok) begin
      case (cmd_op)
        OP_SET:    s_bit = 1'b1;
        OP_RESET:  r_bit = 1'b1;
`ifdef SR_TOGGLE_EN
        OP_TOGGLE: begin
          s_bit = ~q_sel;
          r_bit = q_sel;
        end
`endif
        default: begin
          s_bit = 1'b0;
          r_bit = 1'b0;
        end
      endcase
    end

    // Value the addressed cell takes at the end of APPLY
    cell_nxt = s_bit ? 1'b1 : (r_bit ? 1'b0 : q_sel);
    chk_err  = !idx_ok || !op_ok || (cell_nxt != exp_bit);

    s_vec = '0;
    r_vec = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      s_vec[i] = s_bit && (cmd_idx == IDXW'(i));
      r_vec[i] = r_bit && (cmd_idx == IDXW'(i));
    end
  end

  // Sequencer: IDLE -> GRANT -> APPLY -> CHECK, one cycle each
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      ptr     <= IDW'(NREQ - 1);
      win     <= '0;
      cmd_op  <= OP_HOLD;
      cmd_idx <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            win     <= pick;
            cmd_op  <= pick_op;
            cmd_idx <= pick_idx;
            gnt     <= NREQ'(1) << pick;
            busy    <= 1'b1;
            state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          ptr   <= win;
          state <= S_APPLY;
        end
        S_APPLY: begin
          done  <= NREQ'(1) << win;
          err   <= chk_err;
          state <= S_CHECK;
        end
        S_CHECK: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    sr_cell u_cell (
      .clk (clk),
      .rst (rst),
      .s   (s_vec[g]),
      .r   (r_vec[g]),
      .q   (q_vec[g])
    );
  end

  assign bus.gnt  = gnt;
  assign bus.done = done;
  assign bus.err  = err;
  assign bus.busy = busy;
  assign bus.q    = q_vec;

endmodule

// File: tb/tb_sr_bank_scheduler.sv
// Scoreboard bench for sr_bank_scheduler: random requests against a queue-based
// reference model, plus a WIDTH=6 instance for out-of-range indices.
module tb_sr_bank_scheduler;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDXW  = 3;
  localparam int unsigned OPW   = 2 * NREQ;
  localparam int unsigned IXW   = IDXW * NREQ;

  typedef struct {
    int               cyc;
    logic [NREQ-1:0]  v;
    logic             e;
    logic [WIDTH-1:0] q;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;
  int   busy_lo = -10;
  int   busy_hi = -10;
  int   ptr_m;
  logic [WIDTH-1:0] q_m;
  exp_t gnt_q[$];
  exp_t done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_bank_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) bus ();
  sr_bank_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sr_bank_scheduler_if #(.NREQ(2), .WIDTH(6), .IDXW(3)) bus6 ();
  sr_bank_scheduler #(.NREQ(2), .WIDTH(6), .IDXW(3)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic junk();
    bus.req = NREQ'($urandom);
    bus.op  = OPW'($urandom);
    bus.idx = IXW'($urandom);
  endtask

  // Present one request pattern in an idle cycle and record the expected response.
  task automatic issue(input logic [NREQ-1:0] r, input logic [OPW-1:0] o,
                       input logic [IXW-1:0] x, input bit abort);
    int             t;
    int             w;
    int             c;
    exp_t           e;
    logic [1:0]     op_w;
    logic [IDXW-1:0] ix;
    bus.req = r;
    bus.op  = o;
    bus.idx = x;
    t = cyc + 1;
    if (r == '0) begin
      @(posedge clk); #1;
      return;
    end
    w = -1;
    for (int k = 1; k <= int'(NREQ); k++) begin
      c = (ptr_m + k) % int'(NREQ);
      if (w < 0 && ((r >> c) & NREQ'(1)) != '0) w = c;
    end
    ptr_m = w;
    op_w  = 2'(o >> (2 * w));
    ix    = IDXW'(x >> (int'(IDXW) * w));
    e.cyc = t;
    e.v   = NREQ'(1) << w;
    e.e   = 1'b0;
    e.q   = q_m;
    gnt_q.push_back(e);
    busy_lo = t;
    busy_hi = abort ? t + 1 : t + 2;
    if (abort) begin
      @(posedge clk); #1; junk();
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      check("abort_q", 32'(bus.q), 32'(0));
      check("abort_busy", 32'(bus.busy), 32'(0));
      rst   = 1'b1;
      q_m   = '0;
      ptr_m = int'(NREQ) - 1;
      return;
    end
    case (op_w)
      2'b10: e.q[ix] = 1'b1;
      2'b01: e.q[ix] = 1'b0;
      2'b11: begin
`ifdef SR_TOGGLE_EN
        e.q[ix] = ~e.q[ix];
`else
        e.e = 1'b1;
`endif
      end
      default: ;
    endcase
    q_m   = e.q;
    e.cyc = t + 2;
    done_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k < 3) junk();
    end
  endtask

  task automatic issue6(input logic [1:0] r, input logic [3:0] o, input logic [5:0] x,
                        input logic [1:0] eg, input logic ee, input logic [5:0] eq);
    bus6.req = r;
    bus6.op  = o;
    bus6.idx = x;
    @(posedge clk); #1;
    check("w6_gnt", 32'(bus6.gnt), 32'(eg));
    bus6.req = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("w6_done", 32'(bus6.done), 32'(eg));
    check("w6_err", 32'(bus6.err), 32'(ee));
    check("w6_q", 32'(bus6.q), 32'(eq));
    @(posedge clk); #1;
  endtask

  // Monitor: pops expectations whose cycle has come and compares every cycle
  always @(negedge clk) begin
    logic [NREQ-1:0] ge;
    logic [NREQ-1:0] de;
    logic            ee;
    exp_t            it;
    ge = '0;
    de = '0;
    ee = 1'b0;
    if (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc) begin
      it = gnt_q.pop_front();
      ge = it.v;
    end
    check("gnt", 32'(bus.gnt), 32'(ge));
    if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
      it = done_q.pop_front();
      de = it.v;
      ee = it.e;
      check("q", 32'(bus.q), 32'(it.q));
    end
    check("done", 32'(bus.done), 32'(de));
    check("err", 32'(bus.err), 32'(ee));
    check("busy", 32'(bus.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
    check("s_and_r", 32'(dut.s_vec & dut.r_vec), 32'(0));
    check("s_and_r_w6", 32'(dut6.s_vec & dut6.r_vec), 32'(0));
  end

  initial begin
    int p;
    bus.req  = '1;
    bus.op   = '0;
    bus.idx  = '0;
    bus6.req = '0;
    bus6.op  = '0;
    bus6.idx = '0;
    q_m      = '0;
    ptr_m    = int'(NREQ) - 1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_q", 32'(bus.q), 32'(0));
    check("rst_gnt", 32'(bus.gnt), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    rst = 1'b1;

    // All four requesting SET on their own index: grants 0,1,2,3,0
    for (int i = 0; i < 5; i++) issue(4'hF, 8'b10_10_10_10, 12'o3210, 1'b0);

    // Reset while the op is in APPLY
    issue(4'b0100, 8'b10_10_10_10, 12'o7777, 1'b1);

    issue(4'b0001, 8'b00_00_00_10, 12'o0005, 1'b0);
    issue(4'b0001, 8'b00_00_00_11, 12'o0005, 1'b0);
    issue(4'b0001, 8'b00_00_00_11, 12'o0005, 1'b0);

    for (int n = 0; n < 300; n++) begin
      p = int'($urandom_range(0, 99));
      if (p < 10)
        issue('0, OPW'($urandom), IXW'($urandom), 1'b0);
      else if (p < 13)
        issue(NREQ'($urandom_range(1, 15)), OPW'($urandom), IXW'($urandom), 1'b1);
      else
        issue(NREQ'($urandom_range(1, 15)), OPW'($urandom), IXW'($urandom), 1'b0);
    end

    bus.req = '0;
    @(posedge clk); #1;
    issue6(2'b01, 4'b00_10, 6'o07, 2'b01, 1'b1, 6'h00);
    issue6(2'b10, 4'b10_00, 6'o60, 2'b10, 1'b1, 6'h00);
    issue6(2'b01, 4'b00_10, 6'o05, 2'b01, 1'b0, 6'h20);
`ifdef SR_TOGGLE_EN
    issue6(2'b01, 4'b00_11, 6'o05, 2'b01, 1'b0, 6'h00);
`else
    issue6(2'b01, 4'b00_11, 6'o05, 2'b01, 1'b1, 6'h20);
`endif
    issue6(2'b10, 4'b01_00, 6'o50, 2'b10, 1'b0, 6'h00);

    repeat (2) @(posedge clk);
    #1;
    check("gnt_left", 32'(gnt_q.size()), 32'(0));
    check("done_left", 32'(done_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
